// File: rtl/pmm_pkg.sv
// Shared definitions for the pattern-matching engines: opcodes, control-word
// field positions, window depth and FSM state encoding.
package pmm_pkg;

    localparam int PAT_MAX = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_TEXT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 1;
    localparam int LEN_LSB = 2;
    localparam int LEN_MSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/pmm_window_cmp.sv
// Combinational compare of the post-shift window against the loaded pattern.
// Window byte 0 is the newest byte, so it must equal the last pattern byte.
module pmm_window_cmp
    import pmm_pkg::*;
(
    input  logic [PAT_MAX*8-1:0] win_next,
    input  logic [PAT_MAX*8-1:0] pat,
    input  logic [3:0]           pat_len,
    input  logic [3:0]           fill_next,
    output logic                 hit
);

    logic [PAT_MAX-1:0] byte_ok;

    generate
        for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_byte
            logic [3:0] pidx_full;
            logic [2:0] pidx;
            // Index wraps for positions beyond pat_len; those are masked anyway.
            assign pidx_full = pat_len - 4'(gi) - 4'd1;
            assign pidx      = pidx_full[2:0];
            assign byte_ok[gi] = (4'(gi) >= pat_len) ||
                                 (win_next[gi*8 +: 8] == pat[32'(pidx)*8 +: 8]);
        end
    endgenerate

    assign hit = (fill_next >= pat_len) && (&byte_ok);

endmodule

// File: rtl/pmm_matcher.sv
// One pattern-matching engine: accepts LOAD/TEXT/CLEAR commands, scans text
// one byte per cycle through a persistent sliding window, counts matches.
module pmm_matcher
    import pmm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [63:0]      cmd_data,
    input  logic [15:0]      cmd_ctrl,
    output logic             cmd_ready,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] last_match_pos
);

    state_t state_reg, state_next;

    logic [PAT_MAX*8-1:0] pat_reg;
    logic [3:0]           pat_len_reg;
    logic [PAT_MAX*8-1:0] win_reg;
    logic [3:0]           fill_reg;
    logic [CNT_W-1:0]     pos_reg;
    logic [63:0]          chunk_reg;
    logic [2:0]           idx_reg;
    logic [2:0]           last_idx_reg;
    logic                 match_pulse_reg;
    logic [CNT_W-1:0]     match_count_reg;
    logic [CNT_W-1:0]     last_match_pos_reg;

    logic                 accept;
    logic [1:0]           opcode;
    logic [2:0]           len_m1;
    logic [7:0]           scan_byte;
    logic [PAT_MAX*8-1:0] win_next;
    logic [3:0]           fill_next;
    logic                 hit;
    logic                 unused_ctrl;

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign busy        = ~cmd_ready;
    assign accept      = cmd_valid & cmd_ready;
    assign opcode      = cmd_ctrl[OPC_MSB:OPC_LSB];
    assign len_m1      = cmd_ctrl[LEN_MSB:LEN_LSB];
    assign unused_ctrl = ^cmd_ctrl[15:5];

    assign scan_byte = chunk_reg[32'(idx_reg)*8 +: 8];
    assign win_next  = {win_reg[PAT_MAX*8-9:0], scan_byte};
    assign fill_next = (fill_reg == 4'(PAT_MAX)) ? fill_reg : fill_reg + 4'd1;

    pmm_window_cmp u_cmp (
        .win_next  (win_next),
        .pat       (pat_reg),
        .pat_len   (pat_len_reg),
        .fill_next (fill_next),
        .hit       (hit)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && opcode == OP_TEXT) state_next = ST_SCAN;
            ST_SCAN: if (idx_reg == last_idx_reg)     state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            pat_reg            <= '0;
            pat_len_reg        <= 4'd1;
            win_reg            <= '0;
            fill_reg           <= '0;
            pos_reg            <= '0;
            chunk_reg          <= '0;
            idx_reg            <= '0;
            last_idx_reg       <= '0;
            match_pulse_reg    <= 1'b0;
            match_count_reg    <= '0;
            last_match_pos_reg <= '0;
        end else begin
            state_reg       <= state_next;
            match_pulse_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (accept) begin
                    case (opcode)
                        OP_LOAD: begin
                            pat_reg            <= cmd_data;
                            pat_len_reg        <= {1'b0, len_m1} + 4'd1;
                            fill_reg           <= '0;
                            pos_reg            <= '0;
                            match_count_reg    <= '0;
                            last_match_pos_reg <= '0;
                        end
                        OP_TEXT: begin
                            chunk_reg    <= cmd_data;
                            last_idx_reg <= len_m1;
                            idx_reg      <= '0;
                        end
                        OP_CLEAR: begin
                            fill_reg           <= '0;
                            pos_reg            <= '0;
                            match_count_reg    <= '0;
                            last_match_pos_reg <= '0;
                        end
                        default: ;
                    endcase
                end
            end else begin
                win_reg  <= win_next;
                fill_reg <= fill_next;
                pos_reg  <= pos_reg + 1'b1;
                idx_reg  <= idx_reg + 3'd1;
                if (hit) begin
                    match_pulse_reg    <= 1'b1;
                    last_match_pos_reg <= pos_reg;
                    // Saturate rather than wrap so a long stream never reads as few matches.
                    if (match_count_reg != '1)
                        match_count_reg <= match_count_reg + 1'b1;
                end
            end
        end
    end

    assign match_pulse    = match_pulse_reg;
    assign match_count    = match_count_reg;
    assign last_match_pos = last_match_pos_reg;

endmodule

// File: tb/tb_pmm_matcher.sv
// Directed bench for pmm_matcher: drives commands on the falling edge and
// checks outputs against hand-computed values.
module tb_pmm_matcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic [15:0] cmd_ctrl;
    logic        cmd_ready;
    logic        busy;
    logic        match_pulse;
    logic [15:0] match_count;
    logic [15:0] last_match_pos;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int pulse_pos[$];

    always #5 clk = ~clk;

    pmm_matcher #(.CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ctrl       (cmd_ctrl),
        .cmd_ready      (cmd_ready),
        .busy           (busy),
        .match_pulse    (match_pulse),
        .match_count    (match_count),
        .last_match_pos (last_match_pos)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (match_pulse) pulse_pos.push_back(int'(last_match_pos));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic cmd(input logic [63:0] d, input logic [15:0] c);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_ctrl  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Extra edge lets the monitor record the final pulse before checks.
    task automatic finish_cmds();
        @(negedge clk);
        wait_ready();
        @(negedge clk);
    endtask

    task automatic reset_monitor();
        busy_cnt = 0;
        pulse_pos.delete();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_ctrl  = '0;
        busy_cnt  = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_count", 64'(match_count), 64'd0);
        chk("rst_pos",   64'(last_match_pos), 64'd0);
        chk("rst_pulse", 64'(match_pulse), 64'd0);
        reset = 1'b0;

        // "ab" in "xabab"
        cmd(64'h6261, 16'h0005);
        finish_cmds();
        reset_monitor();
        cmd(64'h62_6162_6178, 16'h0012);
        finish_cmds();
        chk("t2_busy",   64'(busy_cnt), 64'd5);
        chk("t2_npulse", 64'(pulse_pos.size()), 64'd2);
        if (pulse_pos.size() == 2) begin
            chk("t2_p0", 64'(pulse_pos[0]), 64'd2);
            chk("t2_p1", 64'(pulse_pos[1]), 64'd4);
        end
        chk("t2_count", 64'(match_count), 64'd2);
        chk("t2_pos",   64'(last_match_pos), 64'd4);

        // "abc" split across two chunks
        cmd(64'h636261, 16'h0009);
        reset_monitor();
        cmd(64'h6261, 16'h0006);
        cmd(64'h63, 16'h0002);
        finish_cmds();
        chk("t3_npulse", 64'(pulse_pos.size()), 64'd1);
        chk("t3_count",  64'(match_count), 64'd1);
        chk("t3_pos",    64'(last_match_pos), 64'd2);

        // Overlapping "aa", then CLEAR keeps the pattern
        cmd(64'h6161, 16'h0005);
        cmd(64'h61616161, 16'h000E);
        finish_cmds();
        chk("t4_count", 64'(match_count), 64'd3);
        chk("t4_pos",   64'(last_match_pos), 64'd3);
        cmd(64'h0, 16'h0003);
        finish_cmds();
        chk("t4_clr_count", 64'(match_count), 64'd0);
        chk("t4_clr_pos",   64'(last_match_pos), 64'd0);
        cmd(64'h6161, 16'h0006);
        finish_cmds();
        chk("t4_after_count", 64'(match_count), 64'd1);
        chk("t4_after_pos",   64'(last_match_pos), 64'd1);

        // Second TEXT held on cmd_valid during SCAN
        reset_monitor();
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = 64'h616161;
        cmd_ctrl  = 16'h000A;
        @(negedge clk);
        cmd_data  = 64'h6161;
        cmd_ctrl  = 16'h0006;
        chk("t5_busy_hold", 64'(busy), 64'd1);
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        finish_cmds();
        chk("t5_busy",   64'(busy_cnt), 64'd5);
        chk("t5_npulse", 64'(pulse_pos.size()), 64'd5);
        chk("t5_count",  64'(match_count), 64'd6);
        chk("t5_pos",    64'(last_match_pos), 64'd6);

        // Reset during SCAN drops chunk and pattern
        cmd(64'h6261, 16'h0005);
        cmd(64'h6261626162616261, 16'h001E);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ready", 64'(cmd_ready), 64'd1);
        chk("t6_busy",  64'(busy), 64'd0);
        chk("t6_count", 64'(match_count), 64'd0);
        chk("t6_pos",   64'(last_match_pos), 64'd0);
        chk("t6_pulse", 64'(match_pulse), 64'd0);
        reset = 1'b0;
        reset_monitor();
        cmd(64'h62616261, 16'h000E);
        finish_cmds();
        chk("t6_npulse", 64'(pulse_pos.size()), 64'd0);
        chk("t6_after_count", 64'(match_count), 64'd0);
        chk("t6_after_busy",  64'(busy_cnt), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
